// File: rtl/sm83_fetch_pkg.sv
// ---------------------------------------------------------------------------
// sm83_fetch_pkg
//   Shared types for the SM83 instruction fetch stage and the decoder that
//   consumes its bundles.
//   Contents:
//     data_t / instr_t / addr_t  byte, opcode and 16-bit address types
//     imm_len_t                  number of immediate bytes after an opcode
//     fetch_state_t              fetch FSM encoding (also exported for debug)
//     fetch_bundle_t             one complete instruction handed to decode
//     CB_PREFIX                  opcode byte that selects the CB table
//     imm_len()                  immediate length of a non-CB opcode
// ---------------------------------------------------------------------------
package sm83_fetch_pkg;

    typedef logic [7:0]  data_t;
    typedef logic [7:0]  instr_t;
    typedef logic [15:0] addr_t;
    typedef logic [1:0]  imm_len_t;

    localparam data_t CB_PREFIX = 8'hCB;

    typedef enum logic [2:0] {
        S_OP  = 3'd0,   // fetch opcode (or CB prefix)
        S_CB  = 3'd1,   // fetch opcode following the CB prefix
        S_LO  = 3'd2,   // fetch immediate low byte
        S_HI  = 3'd3,   // fetch immediate high byte
        S_OUT = 3'd4,   // present bundle to decode
        S_HLT = 3'd5    // halted, no fetches issued
    } fetch_state_t;

    typedef struct packed {
        instr_t      instr;
        logic        is_cb;
        logic [15:0] imm;
        addr_t       pc;
        addr_t       next_pc;
    } fetch_bundle_t;

    // Immediate length of an unprefixed opcode. CB-prefixed opcodes never
    // carry an immediate, so callers must not apply this to the CB table.
    // Illegal opcodes fall through to 0.
    function automatic imm_len_t imm_len(input data_t op);
        imm_len_t len;
        len = 2'd0;
        case (op)
            8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
            8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA,
            8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC,
            8'hEA, 8'hFA:
                len = 2'd2;
            8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
            8'hE0, 8'hF0, 8'hE8, 8'hF8:
                len = 2'd1;
            default: begin
                // xx110 in block 0 (LD r,d8) and block 3 (ALU A,d8)
                if ((op[2:0] == 3'b110) && ((op[7:6] == 2'b00) || (op[7:6] == 2'b11))) begin
                    len = 2'd1;
                end
            end
        endcase
        return len;
    endfunction

endpackage

// File: rtl/sm83_fetch_if.sv
// ---------------------------------------------------------------------------
// sm83_fetch_if
//   Bus bundle between the fetch stage and its environment (byte memory,
//   decoder, execute control).
//   Signals:
//     mem_req/mem_addr/mem_ack/mem_rdata   byte read port
//     dec_valid/dec_ready/dec_*           instruction bundle to decode
//     redir_valid/redir_pc                 execute redirect
//     halt                                 stop fetching after next handoff
//   Modports:
//     master  fetch stage side
//     slave   memory / decoder / execute side
//
//   Handshakes:
//     memory  - mem_req is held with a stable mem_addr until a cycle with
//               mem_ack high; each such cycle transfers exactly one byte on
//               mem_rdata. mem_ack may be high in the first request cycle.
//               A redirect in the ack cycle discards that byte and the
//               request continues at the new address.
//     decode  - the bundle on dec_* is stable while dec_valid is high and
//               transfers on the clock edge where dec_valid && dec_ready.
//               A redirect in that cycle voids the transfer.
// ---------------------------------------------------------------------------
interface sm83_fetch_if;
    import sm83_fetch_pkg::*;

    logic        mem_req;
    addr_t       mem_addr;
    logic        mem_ack;
    data_t       mem_rdata;

    logic        dec_valid;
    logic        dec_ready;
    instr_t      dec_instr;
    logic        dec_is_cb;
    logic [15:0] dec_imm;
    addr_t       dec_pc;
    addr_t       dec_next_pc;

    logic        redir_valid;
    addr_t       redir_pc;
    logic        halt;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata,
        output dec_valid, dec_instr, dec_is_cb, dec_imm, dec_pc, dec_next_pc,
        input  dec_ready,
        input  redir_valid, redir_pc, halt
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata,
        input  dec_valid, dec_instr, dec_is_cb, dec_imm, dec_pc, dec_next_pc,
        output dec_ready,
        output redir_valid, redir_pc, halt
    );

endinterface

// File: rtl/sm83_fetch.sv
// ---------------------------------------------------------------------------
// sm83_fetch
//   SM83 instruction fetch stage. Walks PC over a byte-wide read port,
//   recognises the CB prefix, gathers 0/1/2 immediate bytes and presents one
//   complete instruction bundle to the decoder.
//   Parameters:
//     RESET_PC   PC loaded at reset (boot ROM entry)
//   Ports:
//     clk        system clock, rising edge
//     rst_n      asynchronous active-low reset
//     bus        sm83_fetch_if.master (memory, decode, redirect, halt)
//     dbg_state  current fetch FSM state
// ---------------------------------------------------------------------------
module sm83_fetch
    import sm83_fetch_pkg::*;
#(
    parameter addr_t RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          rst_n,
    sm83_fetch_if.master  bus,
    output fetch_state_t  dbg_state
);

    fetch_state_t  state_q,  state_d;
    addr_t         pc_q,     pc_d;
    imm_len_t      len_q,    len_d;
    fetch_bundle_t bundle_q, bundle_d;
    // Low during reset so that mem_req stays low until the first edge after
    // reset release, even though the FSM already sits in S_OP.
    logic          run_q,    run_d;

    logic          fetching;
    logic          ack;
    addr_t         pc_inc;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_OP;
            pc_q     <= RESET_PC;
            len_q    <= 2'd0;
            bundle_q <= '0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            len_q    <= len_d;
            bundle_q <= bundle_d;
            run_q    <= run_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        len_d    = len_q;
        bundle_d = bundle_q;
        run_d    = 1'b1;
        pc_inc   = pc_q + 16'd1;    // 16-bit wrap is intended
        // An ack only counts while a request is actually outstanding.
        ack      = bus.mem_ack && fetching;

        if (bus.redir_valid) begin
            // Redirect overrides everything: any ack or decode handshake in
            // this cycle is dropped and fetching restarts at the target.
            state_d        = S_OP;
            pc_d           = bus.redir_pc;
            bundle_d.imm   = '0;
            bundle_d.is_cb = 1'b0;
        end else begin
            case (state_q)
                S_OP: begin
                    if (ack) begin
                        pc_d           = pc_inc;
                        bundle_d.pc    = pc_q;
                        bundle_d.imm   = '0;
                        bundle_d.is_cb = 1'b0;
                        if (bus.mem_rdata == CB_PREFIX) begin
                            state_d = S_CB;
                        end else begin
                            bundle_d.instr = bus.mem_rdata;
                            len_d          = imm_len(bus.mem_rdata);
                            if (imm_len(bus.mem_rdata) == 2'd0) begin
                                state_d          = S_OUT;
                                bundle_d.next_pc = pc_inc;
                            end else begin
                                state_d = S_LO;
                            end
                        end
                    end
                end
                S_CB: begin
                    if (ack) begin
                        pc_d             = pc_inc;
                        bundle_d.instr   = bus.mem_rdata;
                        bundle_d.is_cb   = 1'b1;
                        bundle_d.next_pc = pc_inc;
                        state_d          = S_OUT;
                    end
                end
                S_LO: begin
                    if (ack) begin
                        pc_d              = pc_inc;
                        bundle_d.imm[7:0] = bus.mem_rdata;
                        if (len_q == 2'd2) begin
                            state_d = S_HI;
                        end else begin
                            state_d          = S_OUT;
                            bundle_d.next_pc = pc_inc;
                        end
                    end
                end
                S_HI: begin
                    if (ack) begin
                        pc_d               = pc_inc;
                        bundle_d.imm[15:8] = bus.mem_rdata;
                        bundle_d.next_pc   = pc_inc;
                        state_d            = S_OUT;
                    end
                end
                S_OUT: begin
                    if (bus.dec_ready) begin
                        state_d = bus.halt ? S_HLT : S_OP;
                    end
                end
                S_HLT: begin
                    if (!bus.halt) begin
                        state_d = S_OP;
                    end
                end
                default: begin
                    state_d = S_OP;
                end
            endcase
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        fetching        = run_q && ((state_q == S_OP) || (state_q == S_CB) ||
                                    (state_q == S_LO) || (state_q == S_HI));
        bus.mem_req     = fetching;
        bus.mem_addr    = pc_q;
        bus.dec_valid   = (state_q == S_OUT);
        bus.dec_instr   = bundle_q.instr;
        bus.dec_is_cb   = bundle_q.is_cb;
        bus.dec_imm     = bundle_q.imm;
        bus.dec_pc      = bundle_q.pc;
        bus.dec_next_pc = bundle_q.next_pc;
        dbg_state       = state_q;
    end

endmodule

// File: tb/tb_sm83_fetch.sv
// ---------------------------------------------------------------------------
// tb_sm83_fetch
//   Bench for sm83_fetch: byte memory with random wait states, decoder-side
//   driver, and a reference model that walks the memory image to predict
//   every instruction bundle and every consumed fetch address.
// ---------------------------------------------------------------------------
module tb_sm83_fetch;
    import sm83_fetch_pkg::*;

    localparam int BW = 57;   // {instr, is_cb, imm, pc, next_pc}

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fetch_state_t dbg_state;
    sm83_fetch_if bus();

    sm83_fetch #(.RESET_PC(16'h0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    logic [7:0]    mem [0:65535];
    logic [BW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            max_wait = 0;
    logic [15:0]   exp_addr = 16'h0000;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_len(input logic [7:0] op);
        if (op inside {8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hCA, 8'hD2,
                       8'hDA, 8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC, 8'hEA, 8'hFA})
            return 2;
        if (op inside {8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
                       8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
                       8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
                       8'hE0, 8'hF0, 8'hE8, 8'hF8})
            return 1;
        return 0;
    endfunction

    // Predicts the bundle for the instruction at pc, the following pc and
    // the zero-wait latency in cycles.
    task automatic ref_bundle(input logic [15:0] pc, output logic [BW-1:0] b,
                              output logic [15:0] npc, output int cyc);
        logic [7:0]  op;
        logic [15:0] imm;
        logic        cb;
        int          len;
        op  = mem[pc];
        cb  = 1'b0;
        imm = 16'h0000;
        if (op == 8'hCB) begin
            cb  = 1'b1;
            op  = mem[16'(pc + 16'd1)];
            npc = 16'(pc + 16'd2);
            cyc = 2;
        end else begin
            len = ref_len(op);
            if (len >= 1) imm[7:0]  = mem[16'(pc + 16'd1)];
            if (len == 2) imm[15:8] = mem[16'(pc + 16'd2)];
            npc = 16'(pc + 16'd1 + 16'(len));
            cyc = 1 + len;
        end
        b = {op, cb, imm, pc, npc};
    endtask

    // ---------------- memory responder ----------------
    int   waits_left = 0;
    logic armed      = 1'b0;
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (!bus.mem_req) begin
                bus.mem_ack = 1'b0;
                armed       = 1'b0;
            end else begin
                if (!armed) begin
                    waits_left = int'($urandom_range(max_wait, 0));
                    armed      = 1'b1;
                end
                if (waits_left == 0) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem[bus.mem_addr];
                    armed         = 1'b0;
                end else begin
                    waits_left--;
                    bus.mem_ack = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [BW-1:0] b;
        logic [7:0]    e_instr;
        logic          e_cb;
        logic [15:0]   e_imm, e_pc, e_npc;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_addr = 16'h0000;
            end else begin
                if (bus.mem_req && bus.mem_ack && !bus.redir_valid) begin
                    check_eq("ack_addr", bus.mem_addr, exp_addr);
                    exp_addr = exp_addr + 16'd1;
                end
                if (bus.redir_valid) exp_addr = bus.redir_pc;
                if (bus.dec_valid && bus.dec_ready && !bus.redir_valid) begin
                    if (exp_q.size() == 0) begin
                        check_eq("spurious_bundle", bus.dec_valid, 1'b0);
                    end else begin
                        b = exp_q.pop_front();
                        {e_instr, e_cb, e_imm, e_pc, e_npc} = b;
                        check_eq("dec_instr",   bus.dec_instr,   e_instr);
                        check_eq("dec_is_cb",   bus.dec_is_cb,   e_cb);
                        check_eq("dec_imm",     bus.dec_imm,     e_imm);
                        check_eq("dec_pc",      bus.dec_pc,      e_pc);
                        check_eq("dec_next_pc", bus.dec_next_pc, e_npc);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_redirect(input logic [15:0] pc);
        bus.redir_valid = 1'b1;
        bus.redir_pc    = pc;
        wait_cycle();
        bus.redir_valid = 1'b0;
    endtask

    // Queues n predicted bundles starting at start; returns first latency.
    task automatic push_prog(input logic [15:0] start, input int n, output int first_cyc);
        logic [15:0]   pc, npc;
        logic [BW-1:0] b;
        int            cyc;
        pc        = start;
        first_cyc = 0;
        for (int i = 0; i < n; i++) begin
            ref_bundle(pc, b, npc, cyc);
            if (i == 0) first_cyc = cyc;
            exp_q.push_back(b);
            pc = npc;
        end
    endtask

    task automatic drain(input bit rand_ready);
        int budget;
        budget = 2000;
        while (exp_q.size() != 0 && budget > 0) begin
            bus.dec_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
            wait_cycle();
            budget--;
        end
        bus.dec_ready = 1'b0;
        check_eq("drain_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!bus.dec_valid && n < 100) begin
            wait_cycle();
            n++;
        end
        check_eq(tag, bus.dec_valid, 1'b1);
    endtask

    task automatic wait_state(input fetch_state_t s, input string tag);
        int n;
        n = 0;
        while (dbg_state != s && n < 100) begin
            wait_cycle();
            n++;
        end
        check_eq(tag, dbg_state, s);
    endtask

    task automatic run_seg(input logic [15:0] start, input int n, input bit rand_ready, input bit check_lat);
        int first_cyc, lat;
        bus.dec_ready = 1'b0;
        push_prog(start, n, first_cyc);
        do_redirect(start);
        if (check_lat) begin
            lat = 0;
            while (!bus.dec_valid && lat < 50) begin
                wait_cycle();
                lat++;
            end
            check_eq("latency", lat, first_cyc);
        end
        drain(rand_ready);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int dummy;
        bus.dec_ready   = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = 16'h0000;
        bus.halt        = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i[15:0]] = 8'($urandom);

        // Test 1: reset values, then NOP at 0000 with zero-wait memory
        mem[16'h0000] = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_mem_req",   bus.mem_req,     1'b0);
        check_eq("rst_dec_valid", bus.dec_valid,   1'b0);
        check_eq("rst_mem_addr",  bus.mem_addr,    16'h0000);
        check_eq("rst_instr",     bus.dec_instr,   8'h00);
        check_eq("rst_imm",       bus.dec_imm,     16'h0000);
        check_eq("rst_next_pc",   bus.dec_next_pc, 16'h0000);
        check_eq("rst_state",     dbg_state,       S_OP);
        max_wait = 0;
        push_prog(16'h0000, 1, dummy);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        check_eq("req_before_edge", bus.mem_req, 1'b0);
        wait_cycle();
        check_eq("req_after_release", bus.mem_req, 1'b1);
        check_eq("first_addr", bus.mem_addr, 16'h0000);
        drain(1'b0);

        // Test 2: LD BC,d16 at 0100, zero-wait latency then random waits
        mem[16'h0100] = 8'h01; mem[16'h0101] = 8'h34; mem[16'h0102] = 8'h12;
        max_wait = 0;
        run_seg(16'h0100, 1, 1'b0, 1'b1);
        max_wait = 3;
        run_seg(16'h0100, 1, 1'b1, 1'b0);

        // Test 3: CB 7C then JR 18 FE
        mem[16'h0200] = 8'hCB; mem[16'h0201] = 8'h7C;
        mem[16'h0202] = 8'h18; mem[16'h0203] = 8'hFE;
        max_wait = 0;
        run_seg(16'h0200, 2, 1'b0, 1'b1);
        max_wait = 2;
        run_seg(16'h0200, 2, 1'b1, 1'b0);

        // Test 4: redirect while in S_HI with the ack in the same cycle
        mem[16'h0300] = 8'hC3; mem[16'h0301] = 8'h34; mem[16'h0302] = 8'h12;
        mem[16'h0038] = 8'h00;
        max_wait = 0;
        bus.dec_ready = 1'b0;
        do_redirect(16'h0300);
        wait_state(S_HI, "reach_hi");
        check_eq("ack_in_hi", bus.mem_ack, 1'b1);
        push_prog(16'h0038, 1, dummy);
        do_redirect(16'h0038);
        check_eq("redir_addr",  bus.mem_addr,  16'h0038);
        check_eq("redir_req",   bus.mem_req,   1'b1);
        check_eq("redir_valid", bus.dec_valid, 1'b0);
        check_eq("redir_imm",   bus.dec_imm,   16'h0000);
        check_eq("redir_state", dbg_state,     S_OP);
        drain(1'b0);

        // Test 5: LD A,d8 straddling the PC wrap
        mem[16'hFFFF] = 8'h3E; mem[16'h0000] = 8'h55;
        max_wait = 2;
        run_seg(16'hFFFF, 1, 1'b1, 1'b0);

        // Test 6: halt with decoder stalled, then resume at next_pc
        mem[16'h0400] = 8'h00; mem[16'h0401] = 8'h00;
        max_wait = 1;
        bus.dec_ready = 1'b0;
        bus.halt      = 1'b1;
        push_prog(16'h0400, 1, dummy);
        do_redirect(16'h0400);
        wait_valid("halt_valid");
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_valid",   bus.dec_valid,   1'b1);
            check_eq("stall_req",     bus.mem_req,     1'b0);
            check_eq("stall_pc",      bus.dec_pc,      16'h0400);
            check_eq("stall_next_pc", bus.dec_next_pc, 16'h0401);
            wait_cycle();
        end
        bus.dec_ready = 1'b1;
        wait_cycle();
        bus.dec_ready = 1'b0;
        check_eq("hlt_state", dbg_state,     S_HLT);
        check_eq("hlt_valid", bus.dec_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_eq("hlt_req",  bus.mem_req,  1'b0);
            check_eq("hlt_addr", bus.mem_addr, 16'h0401);
            wait_cycle();
        end
        bus.halt = 1'b0;
        push_prog(16'h0401, 1, dummy);
        wait_cycle();
        check_eq("resume_state", dbg_state,    S_OP);
        check_eq("resume_req",   bus.mem_req,  1'b1);
        check_eq("resume_addr",  bus.mem_addr, 16'h0401);
        drain(1'b0);

        // Randomised programs at random addresses
        for (int k = 0; k < 6; k++) begin
            max_wait = int'($urandom_range(3, 0));
            run_seg(16'($urandom), 8, 1'b1, 1'b0);
        end

        // Asynchronous reset in the middle of S_LO
        mem[16'h0500] = 8'h06; mem[16'h0501] = 8'h77;
        max_wait = 3;
        bus.dec_ready = 1'b0;
        do_redirect(16'h0500);
        wait_state(S_LO, "reach_lo");
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_req",     bus.mem_req,     1'b0);
        check_eq("arst_valid",   bus.dec_valid,   1'b0);
        check_eq("arst_addr",    bus.mem_addr,    16'h0000);
        check_eq("arst_instr",   bus.dec_instr,   8'h00);
        check_eq("arst_is_cb",   bus.dec_is_cb,   1'b0);
        check_eq("arst_imm",     bus.dec_imm,     16'h0000);
        check_eq("arst_pc",      bus.dec_pc,      16'h0000);
        check_eq("arst_next_pc", bus.dec_next_pc, 16'h0000);
        check_eq("arst_state",   dbg_state,       S_OP);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_cycle();
        check_eq("rerun_req",  bus.mem_req,  1'b1);
        check_eq("rerun_addr", bus.mem_addr, 16'h0000);
        repeat (3) wait_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
